mul_arb: RTL and testbench
==========================

MUL_ARB -- requirements
Module: mul_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter IDW, default 3, requester-ID width; SHALL satisfy 2**IDW >= NREQ.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NREQ  per-requester operand valid.
REQ-006 req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_a  input  4*NREQ  packed signed 4-bit multiplicands; slice i belongs to requester i.
REQ-008 req_b  input  4*NREQ  packed unsigned 4-bit multipliers.
REQ-009 rsp_valid  output  1  result valid.
REQ-010 rsp_ready  input  1  consumer accept.
REQ-011 rsp_id  output  IDW  index of the requester that owns the result.
REQ-012 rsp_z  output  8  signed 8-bit product.

Function
REQ-013 Arbitration: round-robin among asserted req_valid bits, starting one past the last granted index; an index that was never granted starts the search at 0.
REQ-014 A grant SHALL occur only when stage S1 can accept: S1 is empty, or S1 advances to S2 in the same cycle.
REQ-015 Handshake: a transfer on requester i occurs when req_valid[i] && req_ready[i]; req_ready is combinational from req_valid and pipeline state.
REQ-016 Pipeline: S1 registers {id, a, b}; the combinational 4x4 signed-by-unsigned multiply operates on S1; S2 registers {id, z} and drives rsp_*.
REQ-017 Latency: a grant in cycle N yields rsp_valid in cycle N+2 when there is no backpressure.
REQ-018 Throughput: one result per cycle under continuous rsp_ready=1.
REQ-019 Backpressure: while rsp_valid && !rsp_ready, S2 holds rsp_id and rsp_z stable; S1 holds if full; req_ready is all-zero once both stages are full.
REQ-020 Simultaneous events: an S2 drain, an S1-to-S2 move and a new grant SHALL all complete in the same cycle without loss or duplication.
REQ-021 Arithmetic: z = sign_extend(a) * zero_extend(b), truncated to 8 bits; range -120..105, no overflow.
REQ-022 The round-robin pointer updates only on an accepted transfer.
REQ-023 Requesters SHALL hold req_a and req_b stable while req_valid is high; the arbiter does not check this.

Reset
REQ-024 On rst_n low, asynchronously: S1 and S2 become empty, rsp_valid=0, rsp_id=0, rsp_z=0, req_ready=0, and the RR pointer points to the last index (NREQ-1) so that index 0 is served first.
REQ-025 Reset mid-operation discards all in-flight operations without emitting a response.
REQ-026 In the first cycle after reset release, grants follow REQ-014 with no idle cycle inserted.

Configuration
REQ-027 Macro MUL_ARB_PRIO_EN: when defined, requester 0 wins whenever req_valid[0]=1; otherwise round-robin among the remaining requesters. Grants to requester 0 do not update the RR pointer.
REQ-028 Without MUL_ARB_PRIO_EN, all requesters use pure round-robin per REQ-013.

Structure
REQ-029 Shared package mul_arb_pkg SHALL hold: OPW=4, ZW=8, the S1 payload struct {id, a, b}, and the S2 payload struct {id, z}.
REQ-030 The multiply SHALL instantiate the existing wallace_tree_multiplier as the only sub-module.
REQ-031 The RR pick SHALL be a function in mul_arb_pkg.

Verification
REQ-032 Single request: req0 a=-3 (0xD), b=5 -> rsp_valid two cycles after the grant, rsp_id=0, rsp_z=0xF1 (-15).
REQ-033 All four requesters valid continuously with rsp_ready=1 -> grants in order 0,1,2,3,0,..., one response per cycle, with the id sequence matching the grant order.
REQ-034 rsp_ready=0 for 5 cycles with all requesters valid -> exactly two operations accepted, rsp_* stable throughout, no loss once rsp_ready returns to 1.
REQ-035 Extremes: a=-8, b=15 -> z=0x88 (-120); a=7, b=15 -> z=0x69 (105); a=0, b=9 -> z=0.
REQ-036 rst_n asserted while both stages are full -> rsp_valid=0 immediately, no stale response after release; first grant after release goes to requester 0.
REQ-037 With MUL_ARB_PRIO_EN defined, req0 held valid and req1..3 valid -> every grant goes to requester 0; when req0 drops, requesters 1, 2, 3 are served in RR order.

Source files
------------

// File: rtl/mul_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_arb_pkg
// Description : Shared types and helpers for the mul_arb multiplier arbiter.
//               Operand/result widths, the S1 payload {id, a, b}, the S2
//               payload {id, z} and the round-robin pick function.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_arb_pkg;

    localparam int OPW      = 4;   // operand width
    localparam int ZW       = 8;   // product width
    localparam int NREQ_MAX = 8;   // largest supported requester count
    localparam int ID_MAXW  = 3;   // id width able to hold any index < NREQ_MAX

    typedef struct packed {
        logic [ID_MAXW-1:0] id;
        logic [OPW-1:0]     a;
        logic [OPW-1:0]     b;
    } s1_t;

    typedef struct packed {
        logic [ID_MAXW-1:0] id;
        logic [ZW-1:0]      z;
    } s2_t;

    typedef struct packed {
        logic               found;
        logic [ID_MAXW-1:0] idx;
    } pick_t;

    // Search starts one past 'last' and wraps at nreq; the first asserted
    // valid bit wins. Bits at or above nreq are never considered.
    function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0] valid,
                                      input logic [ID_MAXW-1:0]  last,
                                      input int                  nreq);
        pick_t p;
        int    idx;
        p = '0;
        for (int i = 1; i <= NREQ_MAX; i++) begin
            idx = (int'(last) + i) % nreq;
            if (i <= nreq && !p.found && valid[idx]) begin
                p.found = 1'b1;
                p.idx   = ID_MAXW'(idx);
            end
        end
        return p;
    endfunction

endpackage : mul_arb_pkg
`default_nettype wire

// File: rtl/mul_arb_wallace.sv
`default_nettype none
// ============================================================================
// Module      : wallace_tree_multiplier
// Description : Combinational 4x4 multiplier, signed multiplicand times
//               unsigned multiplier, 8-bit result. Partial products are
//               reduced with two carry-save (3:2) layers and one final adder.
// Ports       : a (signed OPW), b (unsigned OPW), z (ZW product)
// Revision    : 1.0 - initial release
// ============================================================================
module wallace_tree_multiplier
    import mul_arb_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [ZW-1:0]  z
);

    logic [ZW-1:0] w_a_ext;
    logic [ZW-1:0] w_pp [OPW];
    logic [ZW-1:0] w_s1, w_c1, w_s2, w_c2;

    // Sign-extending a up front makes every partial product correct modulo
    // 2**ZW, so no correction term is needed for the signed operand.
    assign w_a_ext = {{(ZW-OPW){a[OPW-1]}}, a};

    generate
        for (genvar j = 0; j < OPW; j++) begin : g_pp
            assign w_pp[j] = b[j] ? (w_a_ext << j) : '0;
        end
    endgenerate

    assign w_s1 = w_pp[0] ^ w_pp[1] ^ w_pp[2];
    assign w_c1 = ((w_pp[0] & w_pp[1]) | (w_pp[0] & w_pp[2]) | (w_pp[1] & w_pp[2])) << 1;
    assign w_s2 = w_s1 ^ w_c1 ^ w_pp[3];
    assign w_c2 = ((w_s1 & w_c1) | (w_s1 & w_pp[3]) | (w_c1 & w_pp[3])) << 1;
    assign z    = w_s2 + w_c2;

endmodule : wallace_tree_multiplier
`default_nettype wire

// File: rtl/mul_arb.sv
`default_nettype none
// ============================================================================
// Module      : mul_arb
// Description : Round-robin arbiter feeding a two-stage multiply pipeline.
//               S1 holds {id, a, b}; the multiplier works on S1; S2 holds
//               {id, z} and drives the response port.
// Ports       : clk, rst_n (async, active low)
//               req_valid/req_ready [NREQ], req_a/req_b [4*NREQ]
//               rsp_valid, rsp_ready, rsp_id [IDW], rsp_z [8]
// Config      : MUL_ARB_PRIO_EN - requester 0 has absolute priority; others
//               share round-robin. Undefined: pure round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_arb
    import mul_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_z
);

    localparam logic [ID_MAXW-1:0] C_PTR_RST = ID_MAXW'(NREQ - 1);

    logic               r_s1_valid;
    s1_t                r_s1;
    logic               r_s2_valid;
    s2_t                r_s2;
    logic [ID_MAXW-1:0] r_ptr;

    logic               w_s2_ready;
    logic               w_s1_ready;
    logic [NREQ_MAX-1:0] w_valid_ext;
    pick_t              w_pick;
    logic               w_upd_ptr;
    logic               w_grant;
    s1_t                w_s1_next;
    logic [ZW-1:0]      w_z;

    // S2 frees when empty or draining; S1 frees when empty or moving to S2.
    // rst_n gating keeps req_ready low while reset is held.
    assign w_s2_ready  = !r_s2_valid || rsp_ready;
    assign w_s1_ready  = (!r_s1_valid || w_s2_ready) && rst_n;
    assign w_valid_ext = NREQ_MAX'(req_valid);

    always_comb begin
        w_pick    = '0;
        w_upd_ptr = 1'b1;
`ifdef MUL_ARB_PRIO_EN
        if (req_valid[0]) begin
            w_pick.found = 1'b1;
            w_pick.idx   = '0;
            w_upd_ptr    = 1'b0;
        end else begin
            w_pick = rr_pick(w_valid_ext & ~NREQ_MAX'(1), r_ptr, NREQ);
        end
`else
        w_pick = rr_pick(w_valid_ext, r_ptr, NREQ);
`endif
    end

    assign w_grant   = w_pick.found && w_s1_ready;
    assign req_ready = w_grant ? (NREQ'(1) << w_pick.idx) : '0;

    always_comb begin
        w_s1_next    = '0;
        w_s1_next.id = w_pick.idx;
        w_s1_next.a  = req_a[OPW*int'(w_pick.idx) +: OPW];
        w_s1_next.b  = req_b[OPW*int'(w_pick.idx) +: OPW];
    end

    wallace_tree_multiplier u_mult (
        .a (r_s1.a),
        .b (r_s1.b),
        .z (w_z)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
            r_ptr      <= C_PTR_RST;
        end else begin
            if (w_s2_ready) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2.id <= r_s1.id;
                    r_s2.z  <= w_z;
                end
            end
            if (w_s1_ready) begin
                r_s1_valid <= w_grant;
                if (w_grant) begin
                    r_s1 <= w_s1_next;
                end
            end
            if (w_grant && w_upd_ptr) begin
                r_ptr <= w_pick.idx;
            end
        end
    end

    assign rsp_valid = r_s2_valid;
    assign rsp_id    = IDW'(r_s2.id);
    assign rsp_z     = r_s2.z;

endmodule : mul_arb
`default_nettype wire

// File: tb/tb_mul_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_arb
// Description : Directed self-checking bench for mul_arb (NREQ=4, IDW=3).
//               Inputs change on the falling edge; outputs are sampled 1ns
//               later, well away from the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_id;
    logic [7:0]  rsp_z;

    int checks = 0;
    int errors = 0;

    // Operands per requester: 0:-3*5=-15, 1:2*3=6, 2:-1*7=-7, 3:5*4=20
    logic [7:0] exp_z [4] = '{8'hF1, 8'h06, 8'hF9, 8'h14};

    mul_arb #(.NREQ(4), .IDW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_std_ops();
        req_a = {4'h5, 4'hF, 4'h2, 4'hD};
        req_b = {4'h4, 4'h7, 4'h3, 4'h5};
    endtask

    // Leaves at a falling edge with rst_n just released.
    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 4'h0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        set_std_ops();
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_id !== 3'd0) begin errors++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
        checks++; if (rsp_z !== 8'h00) begin errors++; $display("FAIL reset_rsp_z got %h want 00", rsp_z); end
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    endtask

    task automatic test_single();
        do_reset();
        set_std_ops();
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", rsp_valid); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", rsp_valid); end
        checks++; if (rsp_id !== 3'd0) begin errors++; $display("FAIL single_id got %0d want 0", rsp_id); end
        checks++; if (rsp_z !== 8'hF1) begin errors++; $display("FAIL single_z got %h want f1", rsp_z); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        do_reset();
        set_std_ops();
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            exp_rdy = 4'b0001 << (k % 4);
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", k, req_ready, exp_rdy); end
            if (k < 2) begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_latency[%0d] got %b want 0", k, rsp_valid); end
            end else begin
                checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %b want 1", k, rsp_valid); end
                checks++; if (rsp_id !== 3'((k - 2) % 4)) begin errors++; $display("FAIL rr_id[%0d] got %0d want %0d", k, rsp_id, (k - 2) % 4); end
                checks++; if (rsp_z !== exp_z[(k - 2) % 4]) begin errors++; $display("FAIL rr_z[%0d] got %h want %h", k, rsp_z, exp_z[(k - 2) % 4]); end
            end
        end
        req_valid = 4'h0;
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_rdy [10];
        int         exp_id  [10];
        int         accepted;
        exp_rdy = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                    4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        exp_id  = '{-1, -1, 0, 0, 0, 0, 1, 2, 3, -1};
        accepted = 0;
        do_reset();
        set_std_ops();
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 5) rsp_ready = 1'b1;
            if (c == 7) req_valid = 4'h0;
            #1;
            if (c < 5 && (req_ready & req_valid) != 4'h0) accepted++;
            checks++; if (req_ready !== exp_rdy[c]) begin errors++; $display("FAIL bp_ready[%0d] got %b want %b", c, req_ready, exp_rdy[c]); end
            if (exp_id[c] < 0) begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_valid[%0d] got %b want 0", c, rsp_valid); end
            end else begin
                checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", c, rsp_valid); end
                checks++; if (rsp_id !== 3'(exp_id[c])) begin errors++; $display("FAIL bp_id[%0d] got %0d want %0d", c, rsp_id, exp_id[c]); end
                checks++; if (rsp_z !== exp_z[exp_id[c]]) begin errors++; $display("FAIL bp_z[%0d] got %h want %h", c, rsp_z, exp_z[exp_id[c]]); end
            end
            if (c == 4) begin
                checks++; if (accepted != 2) begin errors++; $display("FAIL bp_accepted got %0d want 2", accepted); end
            end
        end
    endtask

    task automatic test_extremes();
        logic [3:0] a_tab [3] = '{4'h8, 4'h7, 4'h0};
        logic [3:0] b_tab [3] = '{4'hF, 4'hF, 4'h9};
        logic [7:0] z_tab [3] = '{8'h88, 8'h69, 8'h00};
        do_reset();
        req_a     = 16'h0000;
        req_b     = 16'h0000;
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (c < 3) begin
                req_valid   = 4'b0010;
                req_a[7:4]  = a_tab[c];
                req_b[7:4]  = b_tab[c];
            end else begin
                req_valid = 4'b0000;
            end
            #1;
            if (c < 3) begin
                checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL ext_grant[%0d] got %b want 0010", c, req_ready); end
            end
            if (c >= 2 && c <= 4) begin
                checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL ext_valid[%0d] got %b want 1", c, rsp_valid); end
                checks++; if (rsp_id !== 3'd1) begin errors++; $display("FAIL ext_id[%0d] got %0d want 1", c, rsp_id); end
                checks++; if (rsp_z !== z_tab[c - 2]) begin errors++; $display("FAIL ext_z[%0d] got %h want %h", c, rsp_z, z_tab[c - 2]); end
            end else if (c == 5) begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ext_drain got %b want 0", rsp_valid); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_std_ops();
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_full got %b want 1", rsp_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL mid_req_ready got %b want 0000", req_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got %b want 0", rsp_valid); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_valid got %b want 1", rsp_valid); end
        checks++; if (rsp_id !== 3'd0) begin errors++; $display("FAIL mid_id got %0d want 0", rsp_id); end
        checks++; if (rsp_z !== 8'hF1) begin errors++; $display("FAIL mid_z got %h want f1", rsp_z); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_drain got %b want 0", rsp_valid); end
    endtask

`ifdef MUL_ARB_PRIO_EN
    task automatic test_priority();
        logic [3:0] exp_rdy [8];
        exp_rdy = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                    4'b0010, 4'b0100, 4'b1000, 4'b0010};
        do_reset();
        set_std_ops();
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 4) req_valid = 4'b1110;
            #1;
            checks++; if (req_ready !== exp_rdy[c]) begin errors++; $display("FAIL prio_grant[%0d] got %b want %b", c, req_ready, exp_rdy[c]); end
            if (c >= 2 && c <= 5) begin
                checks++; if (rsp_id !== 3'd0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL prio_rsp[%0d] got v=%b id=%0d want v=1 id=0", c, rsp_valid, rsp_id); end
            end
        end
        req_valid = 4'h0;
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'h0;
        req_a     = 16'h0;
        req_b     = 16'h0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
`ifdef MUL_ARB_PRIO_EN
        test_priority();
`else
        test_round_robin();
        test_backpressure();
`endif
        test_extremes();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mul_arb
`default_nettype wire
